iserdes_loop_bit: RTL and testbench
===================================

// Module: iserdes_loop_bit
// PURPOSE
//  Single-clock 1:4 serial-to-parallel deserializer for one RITC data bit, with a fixed
//  input delay line and bitslip word alignment. Sits in the RITC datapath; one instance per
//  input bit (3 channels x 12 bits), its 4-bit words feed the per-channel CDC FIFO.
// PARAMETERS
//  LOOP_DELAY        11           fixed delay-line length in CLK cycles applied to D (0..31; 0 = no delay)
//  IODELAY_GRP_NAME  "IODELAY_0"  placement group string; no functional effect
// PORTS
//  CLK       in   1  serial bit clock; single clock domain, all logic on rising edge
//  RST_N     in   1  asynchronous reset, active low
//  D         in   1  serial data bit, one bit per CLK
//  BITSLIP   in   1  slip request, sampled each rising edge
//  BYPASS    out  1  delayed serial stream (delay-line tail), undeserialized
//  Q         out  4  deserialized word; Q[3] = oldest (first received) bit, Q[0] = newest
//  Q_VALID   out  1  one-cycle strobe, high in the cycle after Q is updated
// BEHAVIOUR
//  - Interface: one clock (CLK); reset RST_N is asynchronous and active-low.
//  - Reset (RST_N low, any time incl. mid-word): delay line, shift reg, phase counter,
//    Q, Q_VALID all cleared to 0 immediately; BYPASS = 0.
//  - Delay line: dl[0] <= D; dl[i] <= dl[i-1]; d_del = dl[LOOP_DELAY-1]
//    (d_del = D combinationally when LOOP_DELAY = 0). BYPASS = d_del.
//  - Shift reg: sr <= {sr[1:0], d_del} every edge (3 bits of history kept).
//  - Phase counter ph (2 bits): ph <= ph+1 (wraps 3->0) unless BITSLIP=1, then ph holds.
//  - Capture: on an edge with ph==3 and BITSLIP==0: Q <= {sr[2:0], d_del}, Q_VALID <= 1;
//    otherwise Q holds, Q_VALID <= 0.
//  - After reset release, first capture on the 4th rising edge; thereafter every 4 edges.
//  - Each sampled BITSLIP cycle delays word boundary by one bit (next word starts one bit
//    later); the capture interval containing it is 5 cycles. 4 slips = original alignment.
//  - BITSLIP held high N cycles = N slips; while held, ph frozen and no capture occurs.
//  - BITSLIP in the ph==3 cycle: capture suppressed that cycle, occurs next edge.
//  - Latency: D sampled at edge k is d_del during cycle k+LOOP_DELAY; appears in Q at the
//    first capture edge >= k+LOOP_DELAY+1 at position set by phase.
// STRUCTURE
//  - Shared package ritc_pkg: RATIO = 4, PH_W = 2, MAX_LOOP_DELAY = 31.
//  - One sub-module: loop_delay_line (parameter LEN; D, CLK, RST_N -> delayed bit).
//  - Top holds shift reg, phase counter, capture/valid logic.
// TESTING
//  - Reset: RST_N low mid-stream -> Q=0, Q_VALID=0, BYPASS=0 without waiting for an edge.
//  - Latency, LOOP_DELAY=11: D=1 only at edge 1 after release -> BYPASS=1 between edges
//    11 and 12; Q=4'b0001 with Q_VALID after edge 12; Q=0 at edges 4 and 8.
//  - Alignment, LOOP_DELAY=0: D repeating 1,0,0,0 from edge 1 -> Q=4'b1000 every 4 edges.
//  - Bitslip: same stream, one BITSLIP pulse -> one 5-cycle gap, then Q=4'b0001 steady;
//    4 total pulses -> Q=4'b1000 again.
//  - Slip at ph==3: BITSLIP high on capture edge -> no Q_VALID that edge, Q_VALID next edge.
//  - Cadence: free-run 100 edges, no BITSLIP -> Q_VALID exactly every 4th edge, 25 strobes.

Source files
------------

// File: rtl/ritc_pkg.sv
// Shared constants for the RITC front-end bit deserializers.
package ritc_pkg;
  localparam int unsigned RATIO          = 4;
  localparam int unsigned PH_W           = 2;
  localparam int unsigned MAX_LOOP_DELAY = 31;
  // Phase value on which a word boundary is captured.
  localparam logic [PH_W-1:0] PH_LAST    = PH_W'(RATIO - 1);
endpackage

// File: rtl/loop_delay_line.sv
// Fixed-length shift-register delay for one serial bit; LEN = 0 passes D straight through.
module loop_delay_line #(
  parameter int unsigned LEN = 11
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic D_DEL
);

  if (LEN == 0) begin : g_passthru
    // Gated so the tail still reads 0 while reset is held.
    assign D_DEL = D & RST_N;
  end else begin : g_line
    logic [LEN-1:0] dl_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        dl_q <= '0;
      end else begin
        dl_q[0] <= D;
        for (int i = 1; i < int'(LEN); i++) begin
          dl_q[i] <= dl_q[i-1];
        end
      end
    end

    assign D_DEL = dl_q[LEN-1];
  end

endmodule

// File: rtl/iserdes_loop_bit.sv
// 1:4 deserializer for one RITC data bit: fixed input delay, shift register,
// phase counter with bitslip, and a registered word plus one-cycle valid strobe.
module iserdes_loop_bit
  import ritc_pkg::*;
#(
  parameter int unsigned LOOP_DELAY       = 11,
  parameter              IODELAY_GRP_NAME = "IODELAY_0"
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             D,
  input  logic             BITSLIP,
  output logic             BYPASS,
  output logic [RATIO-1:0] Q,
  output logic             Q_VALID
);

  logic             d_del;
  logic [RATIO-2:0] sr_q, sr_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [RATIO-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             capture;

  loop_delay_line #(.LEN(LOOP_DELAY)) u_delay (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (D),
    .D_DEL (d_del)
  );

  // A slip freezes the phase for one edge, pushing the next word boundary one bit later.
  always_comb begin
    sr_d      = {sr_q[RATIO-3:0], d_del};
    capture   = (ph_q == PH_LAST) && !BITSLIP;
    ph_d      = BITSLIP ? ph_q : ph_q + 1'b1;
    q_d       = q_q;
    q_valid_d = 1'b0;
    if (capture) begin
      q_d       = {sr_q, d_del};
      q_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr_q      <= '0;
      ph_q      <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      ph_q      <= ph_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign BYPASS  = d_del;
  assign Q       = q_q;
  assign Q_VALID = q_valid_q;

endmodule

// File: tb/tb_iserdes_loop_bit.sv
// Bench for iserdes_loop_bit: two instances (delay 11 and 0) share one stimulus stream
// and are checked every cycle against an edge-indexed behavioural model.
module tb_iserdes_loop_bit;

  localparam int LA = 11;
  localparam int LB = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       d = 1'b0;
  logic       bitslip = 1'b0;
  logic       byp_a, byp_b, qv_a, qv_b;
  logic [3:0] q_a, q_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  iserdes_loop_bit #(.LOOP_DELAY(LA)) dut_a (
    .CLK(clk), .RST_N(rst_n), .D(d), .BITSLIP(bitslip),
    .BYPASS(byp_a), .Q(q_a), .Q_VALID(qv_a)
  );

  iserdes_loop_bit #(.LOOP_DELAY(LB)) dut_b (
    .CLK(clk), .RST_N(rst_n), .D(d), .BITSLIP(bitslip),
    .BYPASS(byp_b), .Q(q_b), .Q_VALID(qv_b)
  );

  // ---------------- behavioural model ----------------
  // dhist[e] = D sampled at edge e (1-based since reset release).
  logic       dhist [0:1023];
  int         edge_n = 0;
  int         slips = 0;
  logic [3:0] exp_qa = '0, exp_qb = '0;
  logic       exp_v = 1'b0;

  // Delayed bit seen at edge j by an instance with delay l.
  function automatic logic dd(int l, int j);
    int idx;
    idx = j - l;
    if (idx >= 1 && idx <= edge_n && idx < 1024) return dhist[idx];
    return 1'b0;
  endfunction

  function automatic logic [3:0] word(int l, int k);
    return {dd(l, k-3), dd(l, k-2), dd(l, k-1), dd(l, k)};
  endfunction

  function automatic logic exp_byp(int l);
    if (l == 0) return rst_n & d;
    return dd(l, edge_n + 1);
  endfunction

  // Word boundary at edge k when k minus slips taken before k is a multiple of 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n = 0;
      slips  = 0;
      exp_qa = '0;
      exp_qb = '0;
      exp_v  = 1'b0;
    end else begin
      edge_n++;
      if (edge_n < 1024) dhist[edge_n] = d;
      exp_v = !bitslip && ((edge_n - slips) % 4 == 0);
      if (exp_v) begin
        exp_qa = word(LA, edge_n);
        exp_qb = word(LB, edge_n);
      end
      if (bitslip) slips++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_q_a",   32'(q_a),   32'(exp_qa));
      check("cyc_qv_a",  32'(qv_a),  32'(exp_v));
      check("cyc_byp_a", 32'(byp_a), 32'(exp_byp(LA)));
      check("cyc_q_b",   32'(q_b),   32'(exp_qb));
      check("cyc_qv_b",  32'(qv_b),  32'(exp_v));
      check("cyc_byp_b", 32'(byp_b), 32'(exp_byp(LB)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic d_in, input logic bs_in);
    d       = d_in;
    bitslip = bs_in;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_q_a",   32'(q_a),   32'h0);
    check("rst_qv_a",  32'(qv_a),  32'h0);
    check("rst_byp_a", 32'(byp_a), 32'h0);
    check("rst_q_b",   32'(q_b),   32'h0);
    check("rst_qv_b",  32'(qv_b),  32'h0);
    check("rst_byp_b", 32'(byp_b), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    d       = 1'b0;
    bitslip = 1'b0;
    rst_n   = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int strobes;
    #3;
    do_reset();
    chk_en = 1'b1;

    // Latency: single 1 at edge 1.
    for (int e = 1; e <= 16; e++) begin
      step(e == 1, 1'b0);
      if (e == 4 || e == 8) begin
        check("lat_q_a_early",  32'(q_a),  32'h0);
        check("lat_qv_a_early", 32'(qv_a), 32'h1);
      end
      if (e == 4)  check("lat_q_b_e4", 32'(q_b), 32'b1000);
      if (e == 10) check("lat_byp_e10", 32'(byp_a), 32'h0);
      if (e == 11) check("lat_byp_e11", 32'(byp_a), 32'h1);
      if (e == 12) begin
        check("lat_q_a_e12",  32'(q_a),  32'b0001);
        check("lat_qv_a_e12", 32'(qv_a), 32'h1);
      end
      if (e == 13) check("lat_qv_a_e13", 32'(qv_a), 32'h0);
    end

    // Alignment and bitslip on the zero-delay instance with stream 1,0,0,0.
    do_reset();
    for (int e = 1; e <= 33; e++) begin
      step((e % 4) == 1, (e == 13) || (e >= 22 && e <= 24) || (e == 32));
      if (e == 4 || e == 8 || e == 12 || e == 28) begin
        check("aln_q_b_1000",  32'(q_b),  32'b1000);
        check("aln_qv_b_1000", 32'(qv_b), 32'h1);
      end
      if (e == 14 || e == 15 || e == 16 || e == 25 || e == 26 || e == 27)
        check("slip_gap_qv_b", 32'(qv_b), 32'h0);
      if (e == 17 || e == 21 || e == 33) begin
        check("slip_q_b_0001",  32'(q_b),  32'b0001);
        check("slip_qv_b_0001", 32'(qv_b), 32'h1);
      end
      if (e == 32) check("slip_ph3_qv_b", 32'(qv_b), 32'h0);
    end

    // Mid-stream reset while Q holds data and D is high, then random traffic.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      if (i == 150) begin
        #($urandom_range(1, 6));
        do_reset();
      end
    end

    // Cadence: 100 free-running edges, no slips.
    do_reset();
    strobes = 0;
    for (int e = 1; e <= 100; e++) begin
      step($urandom_range(0, 1) == 1, 1'b0);
      if (qv_a) strobes++;
    end
    check("cadence_strobes", 32'(strobes), 32'd25);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
